// File: rtl/uart_serializer.sv
// -----------------------------------------------------------------------------
// uart_serializer
//
// Transmit-side serial engine of the UART. Takes one word at a time from the
// transmit FIFO over a valid/ready handshake and shifts it out on txd_o as:
//
//   start(0) | DataWidth data bits, LSB first | [parity] | stop(1) [| stop(1)]
//
// Bit timing is derived from the shared oversampling baud tick: every bit
// lasts OverSampleRate ticks. Between ticks nothing moves, so the engine
// freezes cleanly if the baud generator stalls.
//
// Parameters
//   DataWidth       data bits per frame (5..9)
//   OverSampleRate  baud_tick_i pulses per bit period (>= 2)
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous, active-high reset
//   baud_tick_i   single-cycle oversampling tick
//   valid_i       data_i holds a word to send
//   ready_o       engine accepts a word this cycle (registered)
//   data_i        word to transmit
//   parity_en_i   1 = append a parity bit            (latched on transfer)
//   parity_odd_i  1 = odd parity, 0 = even parity    (latched on transfer)
//   two_stop_i    1 = two stop bits, 0 = one         (latched on transfer)
//   txd_o         serial line, idle high (registered)
//   busy_o        frame in progress
//   done_o        one-cycle pulse as the final stop bit ends
// -----------------------------------------------------------------------------
module uart_serializer #(
    parameter int DataWidth      = 8,
    parameter int OverSampleRate = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 two_stop_i,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int TickW = (OverSampleRate > 1) ? $clog2(OverSampleRate) : 1;
    localparam int BitW  = $clog2(DataWidth);

    localparam logic [TickW-1:0] TickLast = TickW'(OverSampleRate - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

    // Frame state encoding.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    logic [2:0]           state_q,      state_d;
    logic [TickW-1:0]     tick_cnt_q,   tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DataWidth-1:0] data_q,       data_d;
    logic                 parity_en_q,  parity_en_d;
    logic                 parity_odd_q, parity_odd_d;
    logic                 two_stop_q,   two_stop_d;
    logic                 txd_d;
    logic                 ready_d;
    logic                 busy_d;
    logic                 done_d;

    // -------------------------------------------------------------------------
    // Decoded conditions
    // -------------------------------------------------------------------------
    logic transfer;     // handshake completes on the coming edge
    logic bit_end;      // current bit period ends on the coming edge
    logic parity_bit;   // parity of the latched word
    logic last_data;    // currently driving the MSB data bit
    logic last_stop;    // currently driving the final stop bit

    assign transfer   = valid_i & ready_o;
    assign bit_end    = baud_tick_i & (tick_cnt_q == TickLast);
    assign parity_bit = (^data_q) ^ parity_odd_q;
    assign last_data  = (bit_cnt_q == BitLast);
    // Stop bits are counted with the bit counter: index 0, or 0..1 for two.
    assign last_stop  = (bit_cnt_q == BitW'(two_stop_q));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // paths that leave it untouched hold the register value instead of
        // inferring a latch.
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        parity_en_d  = parity_en_q;
        parity_odd_d = parity_odd_q;
        two_stop_d   = two_stop_q;
        txd_d        = txd_o;
        ready_d      = ready_o;
        busy_d       = busy_o;
        done_d       = 1'b0;

        if (transfer) begin
            // Accept a word: latch data and frame format, begin the start bit.
            // A tick arriving in this same cycle is deliberately not counted,
            // so the start bit is never shorter than OverSampleRate ticks.
            state_d      = START;
            tick_cnt_d   = '0;
            bit_cnt_d    = '0;
            data_d       = data_i;
            parity_en_d  = parity_en_i;
            parity_odd_d = parity_odd_i;
            two_stop_d   = two_stop_i;
            txd_d        = 1'b0;
            ready_d      = 1'b0;
            busy_d       = 1'b1;
        end else if (state_q != IDLE && baud_tick_i) begin
            if (!bit_end) begin
                tick_cnt_d = tick_cnt_q + TickW'(1);
            end else begin
                tick_cnt_d = '0;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        txd_d     = data_q[0];
                    end
                    DATA: begin
                        if (!last_data) begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                            txd_d     = data_q[bit_cnt_d];
                        end else if (parity_en_q) begin
                            state_d = PARITY;
                            txd_d   = parity_bit;
                        end else begin
                            state_d   = STOP;
                            bit_cnt_d = '0;
                            txd_d     = 1'b1;
                        end
                    end
                    PARITY: begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            // Frame complete: ready rises together with done
                            // so a waiting word is accepted without a gap.
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                        txd_d = 1'b1;
                    end
                    default: begin
                        // Unreachable encodings recover to a clean idle line.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        txd_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples its next value from the same pre-edge state.
        if (rst_i) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            parity_en_q  <= 1'b0;
            parity_odd_q <= 1'b0;
            two_stop_q   <= 1'b0;
            txd_o        <= 1'b1;
            ready_o      <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            parity_en_q  <= parity_en_d;
            parity_odd_q <= parity_odd_d;
            two_stop_q   <= two_stop_d;
            txd_o        <= txd_d;
            ready_o      <= ready_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_serializer
//
// Bench for uart_serializer with OverSampleRate = 4 and DataWidth = 8.
// Words are pushed to a scoreboard when accepted; an independent line
// receiver, which times bits by counting baud ticks, pops each expected
// frame when a start bit appears and compares what it decoded.
// -----------------------------------------------------------------------------
module tb_uart_serializer;

    localparam int Osr = 4;
    localparam int Dw  = 8;

    logic          clk_i        = 1'b0;
    logic          rst_i        = 1'b0;
    logic          baud_tick_i  = 1'b0;
    logic          valid_i      = 1'b0;
    logic [Dw-1:0] data_i       = '0;
    logic          parity_en_i  = 1'b0;
    logic          parity_odd_i = 1'b0;
    logic          two_stop_i   = 1'b0;
    logic          ready_o;
    logic          txd_o;
    logic          busy_o;
    logic          done_o;

    uart_serializer #(
        .DataWidth      (Dw),
        .OverSampleRate (Osr)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .baud_tick_i  (baud_tick_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .two_stop_i   (two_stop_i),
        .txd_o        (txd_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [Dw-1:0] data;
        logic          pe;
        logic          po;
        logic          ts;
    } frame_t;

    frame_t sb[$];

    int checks      = 0;
    int errors      = 0;
    int done_seen   = 0;
    int frames_done = 0;
    int mon_bit     = -1;
    int tick_phase  = 0;
    bit in_frame    = 1'b0;
    bit tick_en     = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Baud tick: one pulse every third clock, changed just after the edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            tick_phase  = (tick_phase == 2) ? 0 : tick_phase + 1;
            baud_tick_i = tick_en && (tick_phase == 0);
        end
    end

    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_seen++;
    end

    // Line receiver. A tick seen at a falling edge is consumed by the DUT on
    // the following rising edge, so a bit ends after Osr observed ticks.
    initial begin
        frame_t f;
        logic   v [0:11];
        logic   val;
        logic [Dw-1:0] rx;
        int     nb, p, cnt, budget;
        bit     ok, aborted;
        forever begin
            @(negedge clk_i);
            if (rst_i !== 1'b0 || txd_o !== 1'b0) continue;
            if (sb.size() == 0) begin
                check("unexpected_start", 1, 0);
                budget = 0;
                while (txd_o === 1'b0 && budget < 2000) begin
                    @(negedge clk_i);
                    budget++;
                end
                continue;
            end
            f        = sb.pop_front();
            p        = f.pe ? 1 : 0;
            nb       = 10 + p + (f.ts ? 1 : 0);
            in_frame = 1'b1;
            aborted  = 1'b0;
            ok       = 1'b1;
            for (int b = 0; b < nb; b++) begin
                mon_bit = b;
                val     = txd_o;
                cnt     = 0;
                budget  = 0;
                forever begin
                    if (rst_i) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd_o !== val || busy_o !== 1'b1 || ready_o !== 1'b0) ok = 1'b0;
                    if (baud_tick_i) cnt++;
                    if (cnt == Osr || budget > 300) break;
                    budget++;
                    @(negedge clk_i);
                end
                if (aborted) break;
                if (cnt != Osr) begin
                    check("bit_timeout", cnt, Osr);
                    aborted = 1'b1;
                    break;
                end
                v[b] = val;
                @(negedge clk_i);
            end
            mon_bit = -1;
            if (!aborted && rst_i === 1'b0) begin
                for (int i = 0; i < Dw; i++) rx[i] = v[i+1];
                check("start_bit", v[0], 0);
                check("rx_data", rx, f.data);
                if (f.pe) check("parity_bit", v[9], (^f.data) ^ f.po);
                check("stop_bit1", v[9+p], 1);
                if (f.ts) check("stop_bit2", v[10+p], 1);
                check("frame_steady", ok, 1);
                check("done_pulse", done_o, 1);
                check("done_busy", busy_o, 0);
                check("done_ready", ready_o, 1);
                frames_done++;
            end
            in_frame = 1'b0;
        end
    end

    // Present a word at a falling edge and wait for the handshake. Returns one
    // falling edge after the accepting rising edge.
    task automatic send(input logic [Dw-1:0] d, input logic pe, input logic po,
                        input logic ts, input bit hold, output bit with_done);
        int budget = 0;
        valid_i      = 1'b1;
        data_i       = d;
        parity_en_i  = pe;
        parity_odd_i = po;
        two_stop_i   = ts;
        with_done    = 1'b0;
        while (ready_o !== 1'b1 && budget < 3000) begin
            @(negedge clk_i);
            budget++;
        end
        if (ready_o !== 1'b1) begin
            check("accept_timeout", 0, 1);
            valid_i = 1'b0;
            return;
        end
        with_done = done_o;
        sb.push_back('{data: d, pe: pe, po: po, ts: ts});
        @(negedge clk_i);
        if (!hold) valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((sb.size() != 0 || in_frame || busy_o !== 1'b0) && budget < 5000) begin
            @(negedge clk_i);
            budget++;
        end
        if (budget >= 5000) check("idle_timeout", busy_o, 0);
    endtask

    task automatic wait_bit(input int n);
        int budget = 0;
        while (mon_bit != n && budget < 2000) begin
            @(negedge clk_i);
            budget++;
        end
        if (mon_bit != n) check("bit_wait_timeout", mon_bit, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit wd;
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_txd", txd_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Plain 8N1 frame, then even and odd parity on 0x07.
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, wd);
        wait_idle();
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, wd);
        wait_idle();
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, wd);
        wait_idle();

        // Two stop bits; config and data inputs change mid-frame.
        send(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, wd);
        two_stop_i   = 1'b0;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b1;
        data_i       = 8'hFF;
        wait_idle();

        // Back-to-back with valid held high.
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, wd);
        send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, wd);
        check("b2b_accept_on_done", wd, 1);
        check("b2b_start_low", txd_o, 0);
        wait_idle();

        // Reset during data bit 3 (a 0 bit of 0xF0).
        send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, wd);
        wait_bit(4);
        repeat (4) @(negedge clk_i);
        check("pre_rst_txd", txd_o, 0);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_txd", txd_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", ready_o, 1);
        check("midrst_done", done_o, 0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, wd);
        wait_idle();

        // Baud tick stalled for 50 cycles during data bit 2 (a 1 bit of 0x96).
        send(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, wd);
        wait_bit(3);
        repeat (2) @(negedge clk_i);
        tick_en = 1'b0;
        repeat (50) @(negedge clk_i);
        check("stall_txd", txd_o, 1);
        check("stall_busy", busy_o, 1);
        tick_en = 1'b1;
        wait_idle();

        repeat (5) @(negedge clk_i);
        check("frames_done", frames_done, 8);
        check("done_count", done_seen, frames_done);
        check("end_txd", txd_o, 1);
        check("end_ready", ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
